scrambler_frame_ctrl: RTL and testbench

Frame-level sequencer for the 43-bit, 12-bit-per-cycle additive scrambler datapath.
- Owns the persistent 43-bit LFSR state register.
- Seeds the register at frame start and advances it one 12-bit beat per accepted input word.
- Counts beats to the frame boundary and presents scrambled words on a registered valid/ready output.
- Sits between the framer (upstream) and the serializer (downstream).

---
 rtl/scrambler_frame_ctrl_if.sv | 32 +++
 rtl/scrambler_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_scrambler_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scrambler_frame_ctrl_if.sv
// ============================================================================
// Module      : scrambler_frame_ctrl_if
// Description : Word stream bus for the scrambler frame controller. It carries
//               the plaintext input side and the scrambled output side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scrambler_frame_ctrl_if #(
    parameter int DW = 12
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    // The master is the environment: it feeds plaintext and sinks scrambled words.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

`default_nettype wire

// File: rtl/scrambler_frame_ctrl.sv
// ============================================================================
// Module      : scrambler_frame_ctrl
// Description : Frame sequencer for a 43-bit, 12-bit-per-beat additive
//               scrambler. Optional macro SCR_BYPASS_EN adds a per-frame
//               bypass that passes plaintext through unscrambled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scrambler_frame_ctrl #(
    parameter int              DW           = 12,
    parameter int              SW           = 43,
    parameter int              LEN_W        = 16,
    parameter logic [SW-1:0]   SEED_DEFAULT = 43'h0000_0000_001
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    input  wire logic              i_abort,
    input  wire logic [LEN_W-1:0]  i_frame_len,
    input  wire logic              i_cfg_seed_sel,
    input  wire logic [SW-1:0]     i_cfg_seed,
`ifdef SCR_BYPASS_EN
    input  wire logic              i_cfg_bypass,
`endif
    scrambler_frame_ctrl_if.slave  bus,
    output logic                   o_busy,
    output logic                   o_err_len0,
    output logic [SW-1:0]          o_state_q
);

    // Feedback taps of x^43 + x^27 + x^22 + x^5 + 1 in the shifted state.
    localparam int c_TAP_A = 5;
    localparam int c_TAP_B = 22;
    localparam int c_TAP_C = 27;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [SW-1:0]      r_seed;
    logic [SW-1:0]      r_lfsr;
    logic [DW-1:0]      r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_err_len0;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_pop;
    logic               w_start_ok;
    logic               w_last_beat;
    logic [SW-1:0]      w_lfsr_step;
    logic [DW-1:0]      w_scr_word;
    logic [SW-1:0]      w_lfsr_adv;
    logic [DW-1:0]      w_out_word;

`ifdef SCR_BYPASS_EN
    logic               r_bypass;
    assign w_lfsr_adv = r_bypass ? r_lfsr       : w_lfsr_step;
    assign w_out_word = r_bypass ? bus.in_data  : w_scr_word;
`else
    assign w_lfsr_adv = w_lfsr_step;
    assign w_out_word = w_scr_word;
`endif

    // Abort gates in_ready so a word offered in the abort cycle is not consumed.
    assign w_in_ready  = (r_state == S_RUN) && !i_abort && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_pop       = r_out_valid && bus.out_ready;
    assign w_start_ok  = i_start && (i_frame_len != '0);
    assign w_last_beat = (r_cnt == (r_len - LEN_W'(1)));

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign o_busy        = (r_state != S_IDLE);
    assign o_err_len0    = r_err_len0;
    assign o_state_q     = r_lfsr;

    always_comb begin : g_scramble
        logic [SW-1:0] v_s;
        logic [SW-1:0] v_ns;
        logic          v_m;
        v_s        = r_lfsr;
        v_ns       = '0;
        v_m        = 1'b0;
        w_scr_word = '0;
        for (int i = 0; i < DW; i++) begin
            v_m           = v_s[SW-1];
            v_ns          = {v_s[SW-2:0], v_m ^ bus.in_data[i]};
            v_ns[c_TAP_A] = v_m ^ v_s[c_TAP_A-1];
            v_ns[c_TAP_B] = v_m ^ v_s[c_TAP_B-1];
            v_ns[c_TAP_C] = v_m ^ v_s[c_TAP_C-1];
            w_scr_word[i] = v_ns[0];
            v_s           = v_ns;
        end
        w_lfsr_step = v_s;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_ok) w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = S_RUN;
                S_RUN:   if (w_accept && w_last_beat) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_pop) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_seed      <= '0;
            r_lfsr      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err_len0  <= 1'b0;
`ifdef SCR_BYPASS_EN
            r_bypass    <= 1'b0;
`endif
        end else begin
            r_err_len0 <= (r_state == S_IDLE) && i_start && (i_frame_len == '0) && !i_abort;
            if (i_abort) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_cnt       <= '0;
            end else begin
                if ((r_state == S_IDLE) && w_start_ok) begin
                    r_len  <= i_frame_len;
                    r_seed <= i_cfg_seed_sel ? i_cfg_seed : SEED_DEFAULT;
`ifdef SCR_BYPASS_EN
                    r_bypass <= i_cfg_bypass;
`endif
                end
                if (r_state == S_LOAD) begin
                    r_lfsr <= r_seed;
                    r_cnt  <= '0;
                end
                if (w_accept) begin
                    r_lfsr      <= w_lfsr_adv;
                    r_out_data  <= w_out_word;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_beat;
                    r_cnt       <= w_last_beat ? '0 : r_cnt + LEN_W'(1);
                end else if (w_pop) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scrambler_frame_ctrl.sv
// ============================================================================
// Module      : tb_scrambler_frame_ctrl
// Description : Directed self-checking bench for scrambler_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scrambler_frame_ctrl;

    localparam logic [42:0] c_MASK = 43'h000_0840_0021;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [15:0]  frame_len = '0;
    logic         cfg_seed_sel = 1'b0;
    logic [42:0]  cfg_seed = '0;
    logic         cfg_bypass = 1'b0;
    logic         busy;
    logic         err_len0;
    logic [42:0]  state_q;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_viol   = 0;
    int           n_err_pulses = 0;
    logic [12:0]  pops[$];

    scrambler_frame_ctrl_if #(.DW(12)) bus ();

    scrambler_frame_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_abort        (abort),
        .i_frame_len    (frame_len),
        .i_cfg_seed_sel (cfg_seed_sel),
        .i_cfg_seed     (cfg_seed),
`ifdef SCR_BYPASS_EN
        .i_cfg_bypass   (cfg_bypass),
`endif
        .bus            (bus),
        .o_busy         (busy),
        .o_err_len0     (err_len0),
        .o_state_q      (state_q)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) pops.push_back({bus.out_last, bus.out_data});
            if (bus.out_valid && !bus.out_ready && bus.in_ready) n_viol++;
            if (err_len0) n_err_pulses++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent Galois-form model: returns {out_word, next_state}.
    function automatic logic [54:0] model(input logic [42:0] s, input logic [11:0] d);
        logic [11:0] o;
        logic        m;
        o = '0;
        for (int i = 0; i < 12; i++) begin
            m = s[42];
            s = {s[41:0], d[i]} ^ (m ? c_MASK : 43'h0);
            o[i] = s[0];
        end
        return {o, s};
    endfunction

    task automatic start_frame(input logic [15:0] len, input logic sel, input logic [42:0] seed);
        start = 1'b1; frame_len = len; cfg_seed_sel = sel; cfg_seed = seed;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] d);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && busy; k++) begin
            @(posedge clk); #1;
        end
        check("idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic single_ffff();
        pops.delete();
        start_frame(16'd1, 1'b1, 43'h0);
        check("busy_load", {63'd0, busy}, 64'd1);
        send_word(12'hFFF);
        @(negedge clk);
        check("t1_valid", {63'd0, bus.out_valid}, 64'd1);
        check("t1_data", {52'd0, bus.out_data}, 64'hFFF);
        check("t1_last", {63'd0, bus.out_last}, 64'd1);
        check("t1_state", {21'd0, state_q}, 64'h000_0000_0FFF);
        @(posedge clk); #1;
        check("t1_busy", {63'd0, busy}, 64'd0);
        check("t1_vclr", {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        logic [42:0] s;
        logic [54:0] r;
        logic [11:0] w4[4];
        logic [11:0] exp_o[4];

        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state_q", {21'd0, state_q}, 64'd0);
        check("rst_out_data", {52'd0, bus.out_data}, 64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_last", {63'd0, bus.out_last}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err_len0}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero seed: plaintext passes through and shifts into the state.
        single_ffff();

        // Only bit 42 set: one feedback hit on the first step.
        start_frame(16'd1, 1'b1, 43'h400_0000_0000);
        send_word(12'h000);
        @(negedge clk);
        check("t2_data", {52'd0, bus.out_data}, 64'h001);
        check("t2_last", {63'd0, bus.out_last}, 64'd1);
        check("t2_state", {21'd0, state_q}, 64'h042_0001_0800);
        wait_idle();

        // Back-pressure with out_ready toggling every cycle.
        w4[0] = 12'h5A5; w4[1] = 12'h3C3; w4[2] = 12'h0F0; w4[3] = 12'hABC;
        s = 43'h123_4567_89AB;
        for (int i = 0; i < 4; i++) begin
            r = model(s, w4[i]);
            exp_o[i] = r[54:43];
            s = r[42:0];
        end
        pops.delete();
        n_viol = 0;
        start_frame(16'd4, 1'b1, 43'h123_4567_89AB);
        fork
            begin
                for (int i = 0; i < 4; i++) send_word(w4[i]);
            end
            begin
                repeat (16) begin
                    @(posedge clk); #1;
                    bus.out_ready = ~bus.out_ready;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_idle();
        check("t3_count", 64'(pops.size()), 64'd4);
        for (int i = 0; i < 4 && i < pops.size(); i++) begin
            check($sformatf("t3_word%0d", i), {51'd0, pops[i]}, {51'd0, (i == 3), exp_o[i]});
        end
        check("t3_hold_viol", 64'(n_viol), 64'd0);
        check("t3_state", {21'd0, state_q}, {21'd0, s});

        // Zero-length frame is rejected.
        n_err_pulses = 0;
        start = 1'b1; frame_len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_err", {63'd0, err_len0}, 64'd1);
        check("t4_busy", {63'd0, busy}, 64'd0);
        check("t4_in_ready", {63'd0, bus.in_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_pulses", 64'(n_err_pulses), 64'd1);
        check("t4_busy2", {63'd0, busy}, 64'd0);

        // Abort mid-frame, then restart from the default seed.
        s = 43'h1;
        for (int i = 0; i < 3; i++) begin
            r = model(s, w4[i]);
            exp_o[i] = r[54:43];
            s = r[42:0];
        end
        for (int pass = 0; pass < 2; pass++) begin
            pops.delete();
            start_frame(16'd8, 1'b0, 43'h7FF_FFFF_FFFF);
            for (int i = 0; i < 3; i++) send_word(w4[i]);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check($sformatf("t5_busy_p%0d", pass), {63'd0, busy}, 64'd0);
            check($sformatf("t5_vclr_p%0d", pass), {63'd0, bus.out_valid}, 64'd0);
            check($sformatf("t5_state_p%0d", pass), {21'd0, state_q}, {21'd0, s});
            check($sformatf("t5_count_p%0d", pass), 64'(pops.size()), 64'd3);
            for (int i = 0; i < 3 && i < pops.size(); i++) begin
                check($sformatf("t5_w%0d_p%0d", i, pass), {51'd0, pops[i]}, {52'd0, exp_o[i]});
            end
        end

        // Reset in the middle of a frame.
        start_frame(16'd4, 1'b1, 43'h0);
        send_word(12'h123);
        send_word(12'h456);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_state_q", {21'd0, state_q}, 64'd0);
        check("t6_out_data", {52'd0, bus.out_data}, 64'd0);
        check("t6_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        single_ffff();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
